// File: rtl/s3g_tx_sched_pkg.sv
// Shared constants, state/kind encodings and the S3G CRC8 step function
// used by both the packet receiver and the response sequencer.
package s3g_tx_sched_pkg;

    localparam logic [7:0] SYNC             = 8'hD5;
    localparam logic [7:0] RESP_OK          = 8'h81;
    localparam logic [7:0] RESP_CRC         = 8'h83;
    localparam int         DEFAULT_MAX_ECHO = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SYNC,
        ST_SEND_LEN,
        ST_SEND_CODE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_SEND_DATA,
        ST_SEND_CRC
    } tx_state_e;

    typedef enum logic {
        KIND_OK  = 1'b0,
        KIND_ERR = 1'b1
    } evt_kind_e;

    // CRC8, polynomial x^8+x^2+x+1, MSB first, one data byte per call.
    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data,
                                               input logic [7:0] crc);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_tx_sched_evt_queue.sv
// Event capture for the response sequencer: a bypassable one-deep pending
// slot plus a saturating counter of events that found the slot occupied.
module s3g_evt_queue
    import s3g_tx_sched_pkg::*;
#(
    parameter int MAX_ECHO = DEFAULT_MAX_ECHO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_packetDone,
    input  logic       i_packetError,
    input  logic [7:0] i_payloadLen,
    input  logic       i_pop,
    output logic       o_valid,
    output evt_kind_e  o_kind,
    output logic [7:0] o_len,
    output logic [7:0] o_dropCnt
);

    localparam logic [7:0] ECHO_CAP = 8'(MAX_ECHO);

    logic       w_evtIn;
    evt_kind_e  w_inKind;
    logic [7:0] w_inLen;

    logic       r_slotValid;
    evt_kind_e  r_kind;
    logic [7:0] r_len;
    logic [7:0] r_dropCnt;

    // An error pulse overrides a simultaneous good-packet pulse.
    assign w_evtIn  = i_packetDone | i_packetError;
    assign w_inKind = i_packetError ? KIND_ERR : KIND_OK;
    assign w_inLen  = i_packetError ? 8'd0 :
                      ((i_payloadLen > ECHO_CAP) ? ECHO_CAP : i_payloadLen);

    assign o_valid   = r_slotValid | w_evtIn;
    assign o_kind    = r_slotValid ? r_kind : w_inKind;
    assign o_len     = r_slotValid ? r_len  : w_inLen;
    assign o_dropCnt = r_dropCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slotValid <= 1'b0;
            r_kind      <= KIND_OK;
            r_len       <= 8'd0;
            r_dropCnt   <= 8'd0;
        end else if (r_slotValid) begin
            if (i_pop) begin
                r_slotValid <= w_evtIn;
                r_kind      <= w_inKind;
                r_len       <= w_inLen;
            end else if (w_evtIn && (r_dropCnt != 8'hFF)) begin
                r_dropCnt <= r_dropCnt + 8'd1;
            end
        end else if (w_evtIn && !i_pop) begin
            r_slotValid <= 1'b1;
            r_kind      <= w_inKind;
            r_len       <= w_inLen;
        end
    end

endmodule

// File: rtl/s3g_tx_sched.sv
// S3G response sequencer: frames SYNC/LEN/CODE/echo/CRC per received-packet
// event and feeds the bytes to the UART over the tx_wr/tx_done handshake.
module s3g_tx_sched
    import s3g_tx_sched_pkg::*;
#(
    parameter int MAX_ECHO = DEFAULT_MAX_ECHO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       packet_done,
    input  logic       packet_error,
    input  logic [7:0] payload_len,
    output logic [7:0] buffer_addr,
    input  logic [7:0] buffer_data,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    logic       w_qValid;
    evt_kind_e  w_qKind;
    logic [7:0] w_qLen;
    logic       w_pop;
    logic       w_sendState;
    logic       w_byteDone;
    logic [7:0] w_txByte;

    tx_state_e  r_state;
    logic       r_sent;
    logic [7:0] r_code;
    logic [7:0] r_echoLen;
    logic [7:0] r_echoCnt;
    logic [7:0] r_rdIdx;
    logic [7:0] r_crc;
    logic [7:0] r_txData;
    logic       r_txWr;
    logic [7:0] r_bufAddr;
    logic       r_busy;

    s3g_evt_queue #(
        .MAX_ECHO (MAX_ECHO)
    ) u_evtQueue (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_packetDone  (packet_done),
        .i_packetError (packet_error),
        .i_payloadLen  (payload_len),
        .i_pop         (w_pop),
        .o_valid       (w_qValid),
        .o_kind        (w_qKind),
        .o_len         (w_qLen),
        .o_dropCnt     (drop_cnt)
    );

    assign w_sendState = (r_state == ST_SEND_SYNC) || (r_state == ST_SEND_LEN) ||
                         (r_state == ST_SEND_CODE) || (r_state == ST_SEND_DATA) ||
                         (r_state == ST_SEND_CRC);
    // tx_done only counts once our write for this state has gone out.
    assign w_byteDone  = w_sendState && r_sent && tx_done;
    assign w_pop       = w_qValid && ((r_state == ST_IDLE) ||
                                      ((r_state == ST_SEND_CRC) && w_byteDone));

    always_comb begin
        w_txByte = 8'd0;
        unique case (r_state)
            ST_SEND_SYNC: w_txByte = SYNC;
            ST_SEND_LEN:  w_txByte = 8'(r_echoLen + 8'd1);
            ST_SEND_CODE: w_txByte = r_code;
            ST_SEND_DATA: w_txByte = buffer_data;
            ST_SEND_CRC:  w_txByte = r_crc;
            default:      w_txByte = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sent    <= 1'b0;
            r_code    <= 8'd0;
            r_echoLen <= 8'd0;
            r_echoCnt <= 8'd0;
            r_rdIdx   <= 8'd0;
            r_crc     <= 8'd0;
            r_txData  <= 8'd0;
            r_txWr    <= 1'b0;
            r_bufAddr <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            r_txWr <= 1'b0;
            if (w_sendState && !r_sent) begin
                r_txWr   <= 1'b1;
                r_txData <= w_txByte;
                r_sent   <= 1'b1;
                if ((r_state == ST_SEND_CODE) || (r_state == ST_SEND_DATA)) begin
                    r_crc <= nextCRC8_D8(w_txByte, r_crc);
                end
            end
            if (w_byteDone) begin
                r_sent <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                end
                ST_SEND_SYNC: if (w_byteDone) r_state <= ST_SEND_LEN;
                ST_SEND_LEN:  if (w_byteDone) r_state <= ST_SEND_CODE;
                ST_SEND_CODE: if (w_byteDone) begin
                    r_state <= (r_echoLen != 8'd0) ? ST_RD_ADDR : ST_SEND_CRC;
                end
                ST_RD_ADDR: begin
                    r_bufAddr <= r_rdIdx;
                    r_state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: r_state <= ST_SEND_DATA;
                ST_SEND_DATA: if (w_byteDone) begin
                    r_rdIdx   <= r_rdIdx + 8'd1;
                    r_echoCnt <= r_echoCnt - 8'd1;
                    r_state   <= (r_echoCnt == 8'd1) ? ST_SEND_CRC : ST_RD_ADDR;
                end
                ST_SEND_CRC: if (w_byteDone) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Starting a frame overrides the CRC-done return to IDLE.
            if (w_pop) begin
                r_state   <= ST_SEND_SYNC;
                r_busy    <= 1'b1;
                r_code    <= (w_qKind == KIND_ERR) ? RESP_CRC : RESP_OK;
                r_echoLen <= w_qLen;
                r_echoCnt <= w_qLen;
                r_rdIdx   <= 8'd0;
                r_crc     <= 8'd0;
            end
        end
    end

    assign buffer_addr = r_bufAddr;
    assign tx_data     = r_txData;
    assign tx_wr       = r_txWr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_s3g_tx_sched.sv
// Directed bench for s3g_tx_sched with a UART model (tx_done 10 cycles after
// each tx_wr) and a registered receive-buffer model.
module tb_s3g_tx_sched;

    logic       clk;
    logic       rst_n;
    logic       packet_done;
    logic       packet_error;
    logic [7:0] payload_len;
    logic [7:0] buffer_addr;
    logic [7:0] buffer_data;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;
    logic       busy;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] rxBytes [$];
    logic [7:0] addrLog [$];
    time        wrTimes [$];
    time        doneTimes [$];
    int         wrWide = 0;

    s3g_tx_sched #(
        .MAX_ECHO (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .packet_done  (packet_done),
        .packet_error (packet_error),
        .payload_len  (payload_len),
        .buffer_addr  (buffer_addr),
        .buffer_data  (buffer_data),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_done      (tx_done),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) buffer_data <= mem[buffer_addr];

    // UART model: capture each write, answer with tx_done ten cycles later.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            if (tx_wr === 1'b1) begin
                rxBytes.push_back(tx_data);
                wrTimes.push_back($time);
                repeat (9) @(posedge clk);
                #1 tx_done = 1'b1;
                doneTimes.push_back($time);
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        logic prevWr;
        logic [7:0] lastAddr;
        prevWr   = 1'b0;
        lastAddr = 8'd0;
        forever begin
            @(posedge clk);
            if ((tx_wr === 1'b1) && prevWr) wrWide++;
            prevWr = (tx_wr === 1'b1);
            #1;
            if (buffer_addr !== lastAddr) begin
                addrLog.push_back(buffer_addr);
                lastAddr = buffer_addr;
            end
        end
    end

    // Bit-serial reference CRC, independent of the byte-wise RTL step.
    function automatic logic [7:0] crcModel(input logic [7:0] bytes [$]);
        logic [7:0] c;
        logic       fb;
        c = 8'd0;
        foreach (bytes[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ bytes[k][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic clearLogs();
        rxBytes.delete();
        addrLog.delete();
        wrTimes.delete();
        doneTimes.delete();
    endtask

    task automatic pulseEvent(input logic d, input logic e, input logic [7:0] len);
        @(posedge clk);
        #1 packet_done = d; packet_error = e; payload_len = len;
        @(posedge clk);
        #1 packet_done = 1'b0; packet_error = 1'b0;
    endtask

    task automatic waitIdle(input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_wr got=%b exp=0", tx_wr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (buffer_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_buffer_addr got=%h exp=00", buffer_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_error_frame();
        logic [7:0] exp [$];
        bit to;
        exp = '{8'hD5, 8'h01, 8'h83, 8'h80};
        clearLogs();
        pulseEvent(1'b0, 1'b1, 8'd9);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL err_busy_start got=%b exp=1", busy); end
        waitIdle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL err_timeout busy never dropped"); end
        checks++; if (doneTimes.size() != 4) begin errors++; $display("[TB] FAIL err_done_count got=%0d exp=4", doneTimes.size()); end
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL err_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL err_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
    endtask

    task automatic test_echo3();
        logic [7:0] exp [$];
        bit to;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
        exp = '{8'hD5, 8'h04, 8'h81, 8'h10, 8'h20, 8'h30, 8'hBB};
        clearLogs();
        pulseEvent(1'b1, 1'b0, 8'd3);
        waitIdle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL echo3_timeout busy never dropped"); end
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL echo3_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL echo3_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
        checks++; if (addrLog.size() != 2 || addrLog[0] !== 8'd1 || addrLog[1] !== 8'd2) begin
            errors++; $display("[TB] FAIL echo3_addr_walk got_changes=%0d exp=2 (1,2)", addrLog.size());
        end
        checks++; if (buffer_addr !== 8'd2) begin errors++; $display("[TB] FAIL echo3_addr_final got=%0d exp=2", buffer_addr); end
    endtask

    task automatic test_max_echo();
        logic [7:0] exp [$];
        logic [7:0] crcIn [$];
        bit to;
        for (int i = 0; i < 40; i++) mem[i] = 8'(i * 7 + 3);
        crcIn = '{8'h81};
        exp   = '{8'hD5, 8'h11, 8'h81};
        for (int i = 0; i < 16; i++) begin
            exp.push_back(mem[i]);
            crcIn.push_back(mem[i]);
        end
        exp.push_back(crcModel(crcIn));
        clearLogs();
        pulseEvent(1'b1, 1'b0, 8'd40);
        waitIdle(4000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL max_timeout busy never dropped"); end
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL max_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL max_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
        checks++; if (addrLog.size() != 16) begin errors++; $display("[TB] FAIL max_addr_steps got=%0d exp=16", addrLog.size()); end
        checks++; if (buffer_addr !== 8'd15) begin errors++; $display("[TB] FAIL max_addr_final got=%0d exp=15", buffer_addr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [$];
        logic [7:0] crcIn [$];
        bit to;
        mem[0] = 8'hA5; mem[1] = 8'h5A;
        crcIn = '{8'h81, 8'hA5, 8'h5A};
        exp   = '{8'hD5, 8'h01, 8'h83, 8'h80, 8'hD5, 8'h03, 8'h81, 8'hA5, 8'h5A};
        exp.push_back(crcModel(crcIn));
        clearLogs();
        pulseEvent(1'b0, 1'b1, 8'd0);
        pulseEvent(1'b1, 1'b0, 8'd2);
        pulseEvent(1'b1, 1'b0, 8'd5);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL b2b_drop_cnt got=%0d exp=1", drop_cnt); end
        waitIdle(4000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL b2b_timeout busy never dropped"); end
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL b2b_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL b2b_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
        checks++;
        if (wrTimes.size() < 5 || doneTimes.size() < 4) begin
            errors++; $display("[TB] FAIL b2b_gap missing events wr=%0d done=%0d", wrTimes.size(), doneTimes.size());
        end else if (wrTimes[4] - doneTimes[3] > 29) begin
            errors++; $display("[TB] FAIL b2b_gap got=%0t exp<=29", wrTimes[4] - doneTimes[3]);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [$];
        bit to;
        exp = '{8'hD5, 8'h01, 8'h83, 8'h80};
        clearLogs();
        pulseEvent(1'b1, 1'b1, 8'd3);
        waitIdle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL sim_timeout busy never dropped"); end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL sim_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL sim_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL sim_drop_cnt got=%0d exp=1", drop_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [$];
        bit to;
        bit reached;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
        exp = '{8'hD5, 8'h04, 8'h81, 8'h10, 8'h20, 8'h30, 8'hBB};
        clearLogs();
        pulseEvent(1'b1, 1'b0, 8'd3);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (rxBytes.size() >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        checks++; if (!reached) begin errors++; $display("[TB] FAIL rstmid_reach got=%0d bytes exp=5", rxBytes.size()); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        repeat (60) @(posedge clk);
        #1;
        checks++; if (rxBytes.size() != 5) begin errors++; $display("[TB] FAIL rstmid_no_more_wr got=%0d exp=5", rxBytes.size()); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_drop_cnt got=%0d exp=0", drop_cnt); end
        clearLogs();
        pulseEvent(1'b1, 1'b0, 8'd3);
        waitIdle(2000, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL rstmid_timeout busy never dropped"); end
        checks++;
        if (rxBytes.size() != exp.size()) begin
            errors++; $display("[TB] FAIL rstmid_frame_len got=%0d exp=%0d", rxBytes.size(), exp.size());
        end else begin
            foreach (exp[i]) if (rxBytes[i] !== exp[i]) begin
                errors++; $display("[TB] FAIL rstmid_byte%0d got=%h exp=%h", i, rxBytes[i], exp[i]);
            end
        end
        checks++; if (wrWide != 0) begin errors++; $display("[TB] FAIL tx_wr_width got=%0d long pulses exp=0", wrWide); end
    endtask

    initial begin
        rst_n        = 1'b0;
        packet_done  = 1'b0;
        packet_error = 1'b0;
        payload_len  = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_error_frame();
        test_echo3();
        test_max_echo();
        test_back_to_back();
        test_simultaneous();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s3g_tx_sched.md
Name: s3g_tx_sched

Overview:
- Response sequencer for the S3G serial link. Sits between the s3g_rx packet receiver and the transmit side of uart_transceiver.
- On each received-packet event it builds a framed S3G response and feeds it byte-by-byte into the UART using the tx_wr/tx_done handshake: sync, length, response code, echoed payload, CRC8.
- Echo payload is fetched from the receiver's packet buffer read port.
- Holds one pending event while a response is in flight, and counts dropped events.

Parameters:
- SYNC, 8'hD5, frame start byte.
- RESP_OK, 8'h81, response code for a good packet.
- RESP_CRC, 8'h83, response code for a CRC-error packet.
- MAX_ECHO, 16, maximum echoed payload bytes (1..254).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- packet_done  in  1  one-cycle pulse, good packet received.
- packet_error  in  1  one-cycle pulse, CRC mismatch.
- payload_len  in  8  received payload length, valid with packet_done.
- buffer_addr  out  8  read address into the receive buffer.
- buffer_data  in  8  buffer read data, valid 1 cycle after buffer_addr.
- tx_data  out  8  byte to UART.
- tx_wr  out  1  one-cycle write strobe to UART.
- tx_done  in  1  one-cycle pulse, UART finished the current byte.
- busy  out  1  high from event acceptance until the CRC byte's tx_done.
- drop_cnt  out  8  saturating count of dropped events.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; tx_wr=0, tx_data=0, buffer_addr=0, busy=0, drop_cnt=0; pending cleared.
- Event capture:
  - packet_done latches kind=OK and echo_len=min(payload_len, MAX_ECHO).
  - packet_error latches kind=ERR and echo_len=0.
  - If both pulse in the same cycle, packet_error wins.
- Queueing:
  - Event in IDLE starts a response in the next cycle.
  - Event while busy goes into the one-deep pending slot.
  - Event while busy with the slot already full increments drop_cnt (saturates at 255); the slot keeps the older event.
  - After the CRC byte completes, a pending event starts with no IDLE bubble longer than 1 cycle.
- Frame: SYNC, LEN = 1 + echo_len, CODE, echo bytes buffer[0..echo_len-1], CRC.
  - CRC is crc8 over CODE and the echo bytes, init 0, using the same nextCRC8_D8 function as the receiver.
- States: IDLE -> SEND_SYNC -> SEND_LEN -> SEND_CODE -> (echo_len>0 ? RD_ADDR -> RD_WAIT -> SEND_DATA, looping : SEND_CRC) -> SEND_CRC -> IDLE.
- Byte handshake:
  - Each SEND_* state drives tx_data and pulses tx_wr for exactly one cycle, then waits for tx_done.
  - The next tx_wr occurs no earlier than 1 cycle after tx_done.
  - tx_done received while not waiting is ignored.
- Buffer read: buffer_addr is set in RD_ADDR; buffer_data is sampled in RD_WAIT+1 (SEND_DATA). The address increments after each data byte, and the 8-bit address never wraps (echo_len <= 254).
- Arithmetic: LEN is computed 8-bit, so MAX_ECHO <= 254 guarantees no overflow; the echo counter decrements to 0.
- Buffer overwrite: if a new packet begins overwriting the buffer mid-echo, the bytes are streamed as read; the stream is not guarded.
- Reset mid-frame: the frame is abandoned immediately and no further tx_wr is issued; the UART finishes its current byte on its own.

Decomposition:
- Shared package/include holds SYNC, RESP_OK, RESP_CRC, the state encodings, and the existing crc8.v function (reused, not duplicated).
- One natural sub-module: s3g_evt_queue, the event latch plus one-deep pending slot and drop counter, presenting a valid/kind/len/pop interface to the sequencer FSM.

Test Plan:
- packet_error pulse, UART model returning tx_done 10 cycles after each tx_wr -> bytes D5, 01, 83, crc8(83); busy drops after the 4th tx_done.
- packet_done with payload_len=3 and buffer {0x10,0x20,0x30} -> D5, 04, 81, 10, 20, 30, crc8(81,10,20,30); buffer_addr walks 0,1,2.
- payload_len=40 with MAX_ECHO=16 -> LEN=0x11, exactly 16 echo bytes, buffer_addr ends at 15.
- Three events while the first response is in flight -> second response sent immediately after the first; drop_cnt=1; no third response.
- packet_done and packet_error in the same cycle -> single ERR response (83); drop_cnt unchanged.
- rst_n low during echo byte 2, held 1 cycle -> no further tx_wr, busy=0, drop_cnt=0; a subsequent packet_done yields a clean full frame.
